// File: rtl/of_pkg.sv
// of_pkg: shared constants and helpers for the operand fetch slice.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default operand width, register index width/count, the x0
// index, and the writeback-hit helper used by the scoreboard and the bypass.
package of_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;
  localparam int NREG         = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Writeback targets register r this cycle; x0 is never a real target.
  function automatic logic reg_hit(input logic en,
                                   input logic [REG_AW-1:0] idx,
                                   input logic [REG_AW-1:0] r);
    return en & (idx == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/of_scoreboard.sv
// of_scoreboard: 32-entry pending-write busy vector with writeback-aware lookup.
// Latency: set/clear land on the next rdclk edge; lookups are combinational.
// Backpressure: none; the caller decides when set_en is allowed.
// Ports: rdclk/rst (async, active-high); set_en/set_idx mark a register busy;
// clr_en/clr_idx release one; q_rs1/q_rs2/q_rd are looked up and reported as
// eff_rs1/eff_rs2/eff_rd (busy and not being released this cycle).
module of_scoreboard
  import of_pkg::*;
(
  input  logic              rdclk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              eff_rs1,
  output logic              eff_rs2,
  output logic              eff_rd
);

  logic [NREG-1:0] busy;

  // Set is checked first so an issue and a writeback to the same register
  // in one cycle leave it busy (the new writer is still outstanding).
  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (set_en && (set_idx == REG_AW'(i)))
          busy[i] <= 1'b1;
        else if (clr_en && (clr_idx == REG_AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  // A register being written back this cycle is resolved by the bypass.
  assign eff_rs1 = busy[q_rs1] & ~reg_hit(clr_en, clr_idx, q_rs1);
  assign eff_rs2 = busy[q_rs2] & ~reg_hit(clr_en, clr_idx, q_rs2);
  assign eff_rd  = busy[q_rd]  & ~reg_hit(clr_en, clr_idx, q_rd);

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads register operands, bypasses writeback, stalls on RAW/WAW.
// Latency: one rdclk cycle from accepted input to out_valid; one per cycle peak.
// Backpressure: in_ready drops on a hazard or when the full output stage is not drained.
// Ports: rdclk, rst (async, active-high); in_* decoded instruction (valid/ready);
// ra/rb register file read addresses, busA/busB read data; wb_regwr/wb_rw/wb_busW
// writeback port (same signals as the register file write port); out_* registered
// operands and payload to execute (valid/ready).
// Option: define OPERAND_FETCH_STALL_CNT_EN to add stall_cnt[31:0], a free-running
// count of cycles where an instruction was presented but held back by a hazard.
module operand_fetch
  import of_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TAGW = 32
) (
  input  logic              rdclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [TAGW-1:0]   in_tag,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  input  logic [XLEN-1:0]   busA,
  input  logic [XLEN-1:0]   busB,
  input  logic              wb_regwr,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic [XLEN-1:0]   wb_busW,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wen,
  output logic [TAGW-1:0]   out_tag
`ifdef OPERAND_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic eff_rs1, eff_rs2, eff_rd;
  logic hazard, issue, set_en;
  logic [XLEN-1:0] opa, opb;

  assign ra = in_rs1;
  assign rb = in_rs2;

  assign set_en = issue & in_wen & (in_rd != REG_ZERO);

  of_scoreboard u_sb (
    .rdclk   (rdclk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (in_rd),
    .clr_en  (wb_regwr),
    .clr_idx (wb_rw),
    .q_rs1   (in_rs1),
    .q_rs2   (in_rs2),
    .q_rd    (in_rd),
    .eff_rs1 (eff_rs1),
    .eff_rs2 (eff_rs2),
    .eff_rd  (eff_rd)
  );

  // WAW only matters when the instruction really writes a non-zero register.
  assign hazard   = in_valid & (eff_rs1 | eff_rs2 |
                                (in_wen & (in_rd != REG_ZERO) & eff_rd));
  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign issue    = in_valid & in_ready;

  // x0 reads as zero even if the register file or writeback says otherwise.
  always_comb begin
    opa = busA;
    opb = busB;
    if (in_rs1 == REG_ZERO)                    opa = '0;
    else if (reg_hit(wb_regwr, wb_rw, in_rs1)) opa = wb_busW;
    if (in_rs2 == REG_ZERO)                    opb = '0;
    else if (reg_hit(wb_regwr, wb_rw, in_rs2)) opb = wb_busW;
  end

  // Data fields hold after a drain so execute sees stable values while idle.
  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_tag   <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_a     <= opa;
      out_b     <= opb;
      out_rd    <= in_rd;
      out_wen   <= in_wen;
      out_tag   <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (hazard)
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scoreboard bench for operand_fetch.
// Stimulus pushes the hand-computed result of each accepted instruction; a
// negedge monitor pops and compares whenever the output stage transfers.
module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int TAGW = 32;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            wen;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic            rdclk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_wen;
  logic [TAGW-1:0] in_tag;
  logic [4:0]      ra, rb;
  logic [XLEN-1:0] busA, busB;
  logic            wb_regwr;
  logic [4:0]      wb_rw;
  logic [XLEN-1:0] wb_busW;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic [TAGW-1:0] out_tag;
`ifdef OPERAND_FETCH_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  int   stall_exp = 0;
  exp_t q[$];
  exp_t mon_e;

  always #5 rdclk = ~rdclk;

  operand_fetch #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .rdclk     (rdclk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_tag    (in_tag),
    .ra        (ra),
    .rb        (rb),
    .busA      (busA),
    .busB      (busB),
    .wb_regwr  (wb_regwr),
    .wb_rw     (wb_rw),
    .wb_busW   (wb_busW),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .out_tag   (out_tag)
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [31:0] tag,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v;  in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_wen = wen;  in_tag = tag; busA = a;     busB = b;
  endtask

  // Expect the presented instruction to be accepted at the next edge.
  task automatic issue(input string name, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    @(negedge rdclk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_ra"}, 32'(ra), 32'(in_rs1));
    e.a = ea; e.b = eb; e.rd = in_rd; e.wen = in_wen; e.tag = in_tag;
    q.push_back(e);
    @(posedge rdclk); #1;
  endtask

  // Expect the presented instruction to be held for one edge.
  task automatic stall(input string name, input logic haz);
    @(negedge rdclk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    @(posedge rdclk); #1;
    if (haz) stall_exp++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge rdclk);
    #1;
  endtask

  // Monitor: every transfer out of the output stage must match the oldest expectation.
  initial begin
    forever begin
      @(negedge rdclk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mon_unexpected: got tag 0x%08h, expected no output", out_tag);
        end else begin
          mon_e = q.pop_front();
          check("mon_a",   out_a,          mon_e.a);
          check("mon_b",   out_b,          mon_e.b);
          check("mon_rd",  32'(out_rd),    32'(mon_e.rd));
          check("mon_wen", 32'(out_wen),   32'(mon_e.wen));
          check("mon_tag", out_tag,        mon_e.tag);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb_regwr = 0; wb_rw = 0; wb_busW = 0; out_ready = 1'b1;
    repeat (2) @(posedge rdclk);
    @(negedge rdclk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a",     out_a,          32'd0);
    check("rst_out_b",     out_b,          32'd0);
    check("rst_out_rd",    32'(out_rd),    32'd0);
    check("rst_out_wen",   32'(out_wen),   32'd0);
    check("rst_out_tag",   out_tag,        32'd0);
    @(posedge rdclk); #1;
    rst = 1'b0;
    @(negedge rdclk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge rdclk); #1;

    // Plain read, no destination.
    drive(1, 1, 2, 0, 0, 32'h100, 32'h11, 32'h22);
    issue("t1", 32'h11, 32'h22);

    // RAW on x5, released by writeback with the bypass overriding stale busA.
    drive(1, 0, 0, 5, 1, 32'h200, 32'h99, 32'h98);
    issue("t2_set", 32'h0, 32'h0);
    drive(1, 5, 0, 0, 0, 32'h201, 32'h5555, 32'h0);
    stall("t2_raw0", 1);
    stall("t2_raw1", 1);
    wb_regwr = 1; wb_rw = 5; wb_busW = 32'hABCD;
    issue("t2_fwd", 32'hABCD, 32'h0);
    wb_regwr = 0;

    // x0 reads zero despite busses and a writeback aimed at x0.
    wb_regwr = 1; wb_rw = 0; wb_busW = 32'h1234;
    drive(1, 0, 0, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("t3_zero", 32'h0, 32'h0);
    // Writeback to a non-busy register still forwards.
    wb_rw = 3; wb_busW = 32'h3333;
    drive(1, 3, 3, 0, 0, 32'h301, 32'h3, 32'h4);
    issue("t3_fwd_nb", 32'h3333, 32'h3333);
    wb_regwr = 0;
    // rd=0 with wen never marks x0 busy.
    drive(1, 0, 0, 0, 1, 32'h302, 32'h0, 32'h0);
    issue("t3_rd0a", 32'h0, 32'h0);
    drive(1, 0, 0, 0, 1, 32'h303, 32'h0, 32'h0);
    issue("t3_rd0b", 32'h0, 32'h0);

    // Set wins over a same-cycle clear on x7.
    drive(1, 0, 0, 7, 1, 32'h400, 32'h0, 32'h0);
    issue("t4_set", 32'h0, 32'h0);
    wb_regwr = 1; wb_rw = 7; wb_busW = 32'h7070;
    drive(1, 0, 0, 7, 1, 32'h401, 32'h0, 32'h0);
    issue("t4_setwin", 32'h0, 32'h0);
    wb_regwr = 0;
    drive(1, 7, 0, 0, 0, 32'h402, 32'hDEAD, 32'h0);
    stall("t4_raw", 1);
    drive(1, 0, 0, 7, 1, 32'h403, 32'h0, 32'h0);
    stall("t4_waw", 1);
    wb_regwr = 1; wb_rw = 7; wb_busW = 32'h7777;
    drive(1, 7, 7, 0, 0, 32'h404, 32'hDEAD, 32'hBEEF);
    issue("t4_fwd", 32'h7777, 32'h7777);
    wb_regwr = 0;

    // Backpressure: output stage holds while out_ready is low.
    idle(2);
    out_ready = 1'b0;
    drive(1, 1, 2, 9, 0, 32'h500, 32'hAAAA, 32'hBBBB);
    issue("t5_x", 32'hAAAA, 32'hBBBB);
    drive(1, 3, 4, 0, 0, 32'h501, 32'hC, 32'hD);
    for (int i = 0; i < 3; i++) begin
      stall("t5_bp", 0);
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_a",     out_a,          32'hAAAA);
      check("t5_hold_tag",   out_tag,        32'h500);
    end
    out_ready = 1'b1;
    issue("t5_y", 32'hC, 32'hD);
    drive(1, 5, 6, 0, 0, 32'h502, 32'hE, 32'hF);
    issue("t5_z", 32'hE, 32'hF);

    // Reset while stalled with an instruction held in the output stage.
    idle(2);
    out_ready = 1'b0;
    drive(1, 0, 0, 5, 1, 32'h600, 32'h0, 32'h0);
    issue("t6_set", 32'h0, 32'h0);
    drive(1, 5, 0, 0, 0, 32'h601, 32'h6161, 32'h0);
    stall("t6_raw0", 1);
    stall("t6_raw1", 1);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("stall_cnt_pre", stall_cnt, 32'(stall_exp));
`endif
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_tag",   out_tag,        32'd0);
    check("t6_rst_wen",   32'(out_wen),   32'd0);
    check("t6_rst_rd",    32'(out_rd),    32'd0);
`ifdef OPERAND_FETCH_STALL_CNT_EN
    check("stall_cnt_rst", stall_cnt, 32'd0);
`endif
    q.delete();
    @(posedge rdclk); #1;
    check("t6_rst_hold", 32'(out_valid), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    issue("t6_after", 32'h6161, 32'h0);

    idle(3);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side companion to the CPU register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses ra/rb.
- Merges busA/busB with a bypass from the writeback port, which uses the same signals as the register file write port.
- Tracks pending destination writes in a 32-entry busy scoreboard, stalls on RAW/WAW hazards, and registers the resolved operands into a single output stage for the execute stage.

Parameters:
- XLEN, 32, data width of operands and busW.
- TAGW, 32, width of pass-through payload (normally PC).

Ports:
- rdclk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  upstream may transfer this cycle.
- in_rs1  in  5  source register 1 index.
- in_rs2  in  5  source register 2 index.
- in_rd  in  5  destination register index.
- in_wen  in  1  instruction writes in_rd.
- in_tag  in  TAGW  payload, passed through.
- ra  out  5  register file read address A; equals in_rs1, combinational.
- rb  out  5  register file read address B; equals in_rs2, combinational.
- busA  in  XLEN  register file read data A, combinational.
- busB  in  XLEN  register file read data B, combinational.
- wb_regwr  in  1  writeback strobe, same as register file regwr.
- wb_rw  in  5  writeback index.
- wb_busW  in  XLEN  writeback data.
- out_valid  out  1  output stage holds an instruction.
- out_ready  in  1  downstream accepts.
- out_a  out  XLEN  resolved operand 1.
- out_b  out  XLEN  resolved operand 2.
- out_rd  out  5  destination index.
- out_wen  out  1  destination write enable.
- out_tag  out  TAGW  payload.

Behaviour:
- Reset (async, rst=1): out_valid=0; out_a, out_b, out_tag, out_rd, out_wen = 0; all busy bits = 0. Outputs are held at these values while rst is high.
- wb_hit(r) = wb_regwr & (wb_rw==r) & (r!=0).
- eff_busy(r) = busy[r] & ~wb_hit(r). Register 0 is never busy.
- Hazard = in_valid and any of:
  - eff_busy(rs1)
  - eff_busy(rs2)
  - in_wen & (in_rd!=0) & eff_busy(rd)
- in_ready = (~out_valid | out_ready) & ~hazard. It is combinational, with no dependency on in_valid other than through hazard.
- Issue = in_valid & in_ready. On the following posedge:
  - out_valid<=1.
  - out_a<=opsel(rs1,busA) and out_b<=opsel(rs2,busB), where opsel(r,bus) = 0 if r==0, else wb_busW if wb_hit(r), else bus.
  - out_rd, out_wen, out_tag are loaded from the inputs.
- No issue & out_ready: out_valid<=0; data outputs hold their last values.
- No issue & ~out_ready: the output stage holds all values.
- Latency: one cycle from an accepted input to out_valid. Throughput is one per cycle when hazard-free and out_ready=1.
- Scoreboard, each posedge:
  - busy[r]<=0 if wb_hit(r).
  - busy[in_rd]<=1 if issue & in_wen & in_rd!=0.
  - When both target the same register in the same cycle, set wins.
  - Writeback to a non-busy register leaves busy unchanged; forwarding still applies.
- Writeback for an instruction still in the output stage is impossible by construction; no special case.
- busy[0] is tied 0. rd=0 with in_wen=1 never sets busy; out_wen is still passed through as given.
- Reset mid-stall: the held instruction is dropped, busy is cleared, and in_ready reevaluates after rst falls.

Optional Feature:
- Macro OPERAND_FETCH_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Reset 0.
  - Increments each cycle in_valid & hazard.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package of_pkg: XLEN default, REG_AW=5, NREG=32, REG_ZERO=5'd0.
- One sub-module of_scoreboard:
  - Inputs: rdclk, rst, set_en, set_idx, clr_en, clr_idx, query indices rs1/rs2/rd.
  - Outputs: the three eff_busy results.
  - Contains the 32-bit busy vector and set-wins-over-clear rule.
- Bypass muxing and the output stage remain in operand_fetch.

Test Plan:
- Reset, then issue rs1=1, rs2=2 with busA=0x11, busB=0x22, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22; no busy set (in_wen=0).
- Issue rd=5, in_wen=1; next instruction rs1=5 -> in_ready=0 (stall). Then pulse wb_regwr, wb_rw=5, wb_busW=0xABCD -> in_ready=1 that cycle; out_a=0xABCD next cycle, ignoring the stale busA.
- rs1=0, rs2=0 with busA=busB=0xFFFFFFFF, and wb_rw=0 asserted with 0x1234 -> out_a=out_b=0; no busy change.
- Same cycle: wb clears x7 and a new issue with rd=7, in_wen=1 -> busy[7]=1 afterwards; a following read of x7 stalls.
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> next instruction accepted, back-to-back at one per cycle.
- Assert rst mid-stall with busy[5]=1 -> out_valid=0 immediately and busy cleared; after release, rs1=5 issues without stall. With OPERAND_FETCH_STALL_CNT_EN, stall_cnt reads 0 after reset and counts the prior stalled cycles before it.
